// File: rtl/pu_bus_sequencer.sv
`timescale 1ns/1ps
// pu_bus_sequencer
// Steps through a small program of control words and drives the per-PU
// signal_sel / signal_wr / signal_oe strobes (oe && wr is the launch strobe).
// Merges every PU's data_out/attr_out onto one broadcast bus and flags
// transfers whose attribute carries the INVALID bit.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   prog_we/addr/data   program memory write port (honoured only in IDLE)
//   start               run request (ignored unless IDLE)
//   busy                high from FETCH through DONE
//   done                one-cycle pulse at program end
//   err                 sticky: an illegal control word was executed
//   invalid_seen        sticky: a read transfer carried the INVALID attribute
//   pu_signal_sel/wr/oe per-PU strobes, nonzero only in EXEC
//   pu_data_out/attr_out flattened PU outputs, slot i at [i*W +: W]
//   bus_data/bus_attr   OR-merge of all PU outputs, broadcast to PU inputs
//
// Control word, LSB first: end, launch_en, launch_idx, dst_sel, dst_idx,
// dst_en, src_sel, src_idx, src_en, wait[3:0].
//
// Build option: define PU_BUS_SEQ_HALT_ON_INVALID_EN to end the run (go to
// DONE) right after an EXEC that performed an invalid transfer.
module pu_bus_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ATTR_WIDTH = 4,
  parameter int INVALID    = 0,
  parameter int PU_COUNT   = 4,
  parameter int PROG_DEPTH = 16,
  parameter int IDX_W      = $clog2(PU_COUNT),
  parameter int PC_W       = $clog2(PROG_DEPTH),
  parameter int CW_WIDTH   = 3*IDX_W+10
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             prog_we,
  input  logic [PC_W-1:0]                  prog_addr,
  input  logic [CW_WIDTH-1:0]              prog_data,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  output logic                             err,
  output logic                             invalid_seen,
  output logic [PU_COUNT-1:0]              pu_signal_sel,
  output logic [PU_COUNT-1:0]              pu_signal_wr,
  output logic [PU_COUNT-1:0]              pu_signal_oe,
  input  logic [PU_COUNT*DATA_WIDTH-1:0]   pu_data_out,
  input  logic [PU_COUNT*ATTR_WIDTH-1:0]   pu_attr_out,
  output logic [DATA_WIDTH-1:0]            bus_data,
  output logic [ATTR_WIDTH-1:0]            bus_attr
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PROG_DEPTH-1);

  logic [2:0]          state;
  logic [PC_W-1:0]     pc;
  logic [CW_WIDTH-1:0] cw;
  logic [3:0]          wait_cnt;
  logic [CW_WIDTH-1:0] mem [PROG_DEPTH];

  // Control word fields
  logic             f_end, launch_en, dst_sel, dst_en, src_sel, src_en;
  logic [IDX_W-1:0] launch_idx, dst_idx, src_idx;
  logic [3:0]       f_wait;

  assign f_end      = cw[0];
  assign launch_en  = cw[1];
  assign launch_idx = cw[IDX_W+1:2];
  assign dst_sel    = cw[IDX_W+2];
  assign dst_idx    = cw[2*IDX_W+2:IDX_W+3];
  assign dst_en     = cw[2*IDX_W+3];
  assign src_sel    = cw[2*IDX_W+4];
  assign src_idx    = cw[3*IDX_W+4:2*IDX_W+5];
  assign src_en     = cw[3*IDX_W+5];
  assign f_wait     = cw[3*IDX_W+9:3*IDX_W+6];

  logic illegal;
  logic invalid_now;
  logic last_step;
  logic halt;

  // Two enabled fields addressing the same PU would give it conflicting strobes.
  assign illegal = (src_en && dst_en    && (src_idx == dst_idx))    ||
                   (src_en && launch_en && (src_idx == launch_idx)) ||
                   (dst_en && launch_en && (dst_idx == launch_idx));

  assign invalid_now = (state == S_EXEC) && src_en && bus_attr[INVALID];
  assign last_step   = f_end || (pc == PC_LAST);

`ifdef PU_BUS_SEQ_HALT_ON_INVALID_EN
  assign halt = invalid_now;
`else
  assign halt = 1'b0;
`endif

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // Broadcast bus: idle PUs drive zero, so OR acts as the bus mux.
  always_comb begin
    bus_data = '0;
    bus_attr = '0;
    for (int unsigned i = 0; i < PU_COUNT; i++) begin
      bus_data = bus_data | pu_data_out[i*DATA_WIDTH +: DATA_WIDTH];
      bus_attr = bus_attr | pu_attr_out[i*ATTR_WIDTH +: ATTR_WIDTH];
    end
  end

  // Strobes; launch is applied last so it overrides sel for its slot.
  always_comb begin
    pu_signal_sel = '0;
    pu_signal_wr  = '0;
    pu_signal_oe  = '0;
    if ((state == S_EXEC) && !illegal) begin
      if (src_en) begin
        pu_signal_oe[src_idx]  = 1'b1;
        pu_signal_sel[src_idx] = src_sel;
      end
      if (dst_en) begin
        pu_signal_wr[dst_idx]  = 1'b1;
        pu_signal_sel[dst_idx] = dst_sel;
      end
      if (launch_en) begin
        pu_signal_oe[launch_idx]  = 1'b1;
        pu_signal_wr[launch_idx]  = 1'b1;
        pu_signal_sel[launch_idx] = 1'b0;
      end
    end
  end

  // Program memory: no reset, so contents survive rst.
  always_ff @(posedge clk) begin
    if (prog_we && (state == S_IDLE)) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      pc           <= '0;
      cw           <= '0;
      wait_cnt     <= '0;
      err          <= 1'b0;
      invalid_seen <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            pc           <= '0;
            err          <= 1'b0;
            invalid_seen <= 1'b0;
            state        <= S_FETCH;
          end
        end
        S_FETCH: begin
          cw    <= mem[pc];
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (illegal)     err          <= 1'b1;
          if (invalid_now) invalid_seen <= 1'b1;
          if (halt) begin
            state <= S_DONE;
          end else if (f_wait != 4'd0) begin
            wait_cnt <= f_wait - 4'd1;
            state    <= S_WAIT;
          end else if (last_step) begin
            state <= S_DONE;
          end else begin
            pc    <= pc + PC_W'(1);
            state <= S_FETCH;
          end
        end
        S_WAIT: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else if (last_step) begin
            state <= S_DONE;
          end else begin
            pc    <= pc + PC_W'(1);
            state <= S_FETCH;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
